// File: rtl/bus_unrotate_if.sv
// Handshake bundle for the receive-side unrotate stage: rotated words in, restored words out.
// The master drives the input word and the downstream ready; the slave is the unrotate block.
interface bus_unrotate_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHIFT_W = 4,
    parameter int unsigned CNT_W   = 16
);
    logic [WIDTH-1:0]   bus_in;
    logic               ena_in;
    logic [SHIFT_W-1:0] rot_amt;
    logic               in_ready;
    logic [WIDTH-1:0]   bus_out;
    logic               ena_out;
    logic               out_ready;
    logic [CNT_W-1:0]   word_count;

    modport master (
        output bus_in, ena_in, rot_amt, out_ready,
        input  in_ready, bus_out, ena_out, word_count
    );

    modport slave (
        input  bus_in, ena_in, rot_amt, out_ready,
        output in_ready, bus_out, ena_out, word_count
    );
endinterface

// File: rtl/bus_unrotate.sv
// Undoes an upstream right-rotate by rotating each word left by rot_amt.
// Two-stage pipeline (capture, rotate) with ena/ready flow control and a delivered-word counter.
module bus_unrotate #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHIFT_W = 4,
    parameter int unsigned CNT_W   = 16
) (
    input logic           clk,
    input logic           rst_n,
    bus_unrotate_if.slave bus
);

    if ((64'd1 << SHIFT_W) < 64'(WIDTH)) begin : g_bad_shift_w
        $error("bus_unrotate: 2**SHIFT_W must be >= WIDTH");
    end

    logic [WIDTH-1:0]   s1_data_q, s1_data_d;
    logic [SHIFT_W-1:0] s1_amt_q, s1_amt_d;
    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]   s2_data_q, s2_data_d;
    logic               s2_valid_q, s2_valid_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               s2_adv;
    logic               in_ready;
    logic               in_xfer;
    logic               out_xfer;
    logic [SHIFT_W-1:0] amt_mod;
    logic [WIDTH-1:0]   rotated;

    assign s2_adv   = s1_valid_q && (!s2_valid_q || bus.out_ready);
    // Ready looks through stage 2 so a full pipe still streams at one word per clock.
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_xfer  = bus.ena_in && in_ready;
    assign out_xfer = s2_valid_q && bus.out_ready;

    assign amt_mod  = SHIFT_W'(32'(bus.rot_amt) % WIDTH);
    // Left rotate as a window into the doubled word; amt = 0 selects the word itself.
    assign rotated  = WIDTH'({s1_data_q, s1_data_q} >> (WIDTH - 32'(s1_amt_q)));

    always_comb begin
        s1_data_d  = s1_data_q;
        s1_amt_d   = s1_amt_q;
        s1_valid_d = s1_valid_q;
        s2_data_d  = s2_data_q;
        s2_valid_d = s2_valid_q;
        count_d    = count_q + CNT_W'(out_xfer);

        if (in_xfer) begin
            s1_data_d  = bus.bus_in;
            s1_amt_d   = amt_mod;
            s1_valid_d = 1'b1;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_adv) begin
            s2_data_d  = rotated;
            s2_valid_d = 1'b1;
        end else if (out_xfer) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q  <= '0;
            s1_amt_q   <= '0;
            s1_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_valid_q <= 1'b0;
            count_q    <= '0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_amt_q   <= s1_amt_d;
            s1_valid_q <= s1_valid_d;
            s2_data_q  <= s2_data_d;
            s2_valid_q <= s2_valid_d;
            count_q    <= count_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.bus_out    = s2_data_q;
    assign bus.ena_out    = s2_valid_q;
    assign bus.word_count = count_q;

endmodule

// File: tb/tb_bus_unrotate.sv
// Scoreboard bench for bus_unrotate: drivers queue the expected restored word on issue,
// a negedge monitor pops and compares on every output transfer.
module tb_bus_unrotate;

    logic clk;
    logic rst_n;

    bus_unrotate_if #(.WIDTH(16), .SHIFT_W(4), .CNT_W(16)) bus ();

    bus_unrotate #(.WIDTH(16), .SHIFT_W(4), .CNT_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    logic [15:0] exp_q[$];
    logic [15:0] exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted output word must be the next one queued, in order.
    always @(negedge clk) begin
        if (rst_n && bus.ena_out && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got %h, expected no word (t=%0t)",
                         bus.bus_out, $time);
            end else begin
                chk("scoreboard_data", 32'(bus.bus_out), 32'(exp_q.pop_front()));
            end
            chk("scoreboard_count", 32'(bus.word_count), 32'(exp_cnt));
            exp_cnt = exp_cnt + 16'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted; expected restored value goes on the queue.
    task automatic send(input logic [15:0] data, input logic [3:0] amt, input logic [15:0] expd);
        bit ok = 1'b0;
        bus.bus_in  = data;
        bus.rot_amt = amt;
        bus.ena_in  = 1'b1;
        exp_q.push_back(expd);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            tick();
            if (ok) break;
        end
        bus.ena_in = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 for 50 clks, expected 1 (data %h)", data);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [15:0] rotr(input logic [15:0] x, input int n);
        return (x >> n) | (x << (16 - n));
    endfunction

    initial begin
        n_vec         = 0;
        n_err         = 0;
        exp_cnt       = '0;
        rst_n         = 1'b0;
        bus.bus_in    = '0;
        bus.ena_in    = 1'b0;
        bus.rot_amt   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        tick();
        @(negedge clk);
        chk("rst_ena_out", 32'(bus.ena_out), 32'd0);
        chk("rst_bus_out", 32'(bus.bus_out), 32'h0);
        chk("rst_word_count", 32'(bus.word_count), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // 1) Inverse check and latency
        bus.out_ready = 1'b1;
        send(16'h8000, 4'd1, 16'h0001);
        @(negedge clk);
        chk("t1_not_yet", 32'(bus.ena_out), 32'd0);
        tick();
        @(negedge clk);
        chk("t1_ena_out", 32'(bus.ena_out), 32'd1);
        chk("t1_bus_out", 32'(bus.bus_out), 32'h0001);
        tick();
        drain();

        // 2) Sweep all rotate amounts
        do_reset();
        bus.out_ready = 1'b1;
        for (int a = 0; a < 16; a++) send(rotr(16'hA5C3, a), 4'(a), 16'hA5C3);
        drain();
        chk("t2_word_count", 32'(bus.word_count), 32'd16);

        // 3) Backpressure: two words fill the pipe, the third is held off
        bus.out_ready = 1'b0;
        send(16'h1234, 4'd4, 16'h2341);
        send(16'h5678, 4'd4, 16'h6785);
        bus.bus_in  = 16'h9ABC;
        bus.rot_amt = 4'd4;
        bus.ena_in  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_in_ready_low", 32'(bus.in_ready), 32'd0);
            chk("t3_ena_out_held", 32'(bus.ena_out), 32'd1);
            chk("t3_bus_out_held", 32'(bus.bus_out), 32'h2341);
            tick();
        end
        bus.out_ready = 1'b1;
        send(16'h9ABC, 4'd4, 16'hABC9);
        send(16'hDEF0, 4'd4, 16'hEF0D);
        @(negedge clk);
        chk("t3_no_gap_a", 32'(bus.ena_out), 32'd1);
        tick();
        @(negedge clk);
        chk("t3_no_gap_b", 32'(bus.ena_out), 32'd1);
        tick();
        drain();
        chk("t3_word_count", 32'(bus.word_count), 32'd20);

        // 6) Full pipe: one out and one in on the same edge
        bus.out_ready = 1'b0;
        send(16'h1200, 4'd8, 16'h0012);
        send(16'h00AB, 4'd12, 16'hB00A);
        bus.bus_in    = 16'h8001;
        bus.rot_amt   = 4'd15;
        bus.ena_in    = 1'b1;
        bus.out_ready = 1'b1;
        exp_q.push_back(16'hC000);
        @(negedge clk);
        chk("t6_in_ready_full", 32'(bus.in_ready), 32'd1);
        tick();
        bus.ena_in    = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t6_still_full", 32'(bus.in_ready), 32'd0);
        chk("t6_next_word", 32'(bus.bus_out), 32'hB00A);
        tick();
        bus.out_ready = 1'b1;
        drain();
        chk("t6_word_count", 32'(bus.word_count), 32'd23);

        // 5) Reset with two words in flight
        bus.out_ready = 1'b0;
        send(16'h0001, 4'd1, 16'h0002);
        send(16'h4000, 4'd2, 16'h0001);
        @(negedge clk);
        chk("t5_pre_ena_out", 32'(bus.ena_out), 32'd1);
        chk("t5_pre_count", 32'(bus.word_count), 32'd23);
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        #1;
        chk("t5_rst_ena_out", 32'(bus.ena_out), 32'd0);
        chk("t5_rst_count", 32'(bus.word_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.out_ready = 1'b1;
        send(16'h0003, 4'd3, 16'h0018);
        @(negedge clk);
        chk("t5_post_not_yet", 32'(bus.ena_out), 32'd0);
        tick();
        @(negedge clk);
        chk("t5_post_ena_out", 32'(bus.ena_out), 32'd1);
        chk("t5_post_bus_out", 32'(bus.bus_out), 32'h0018);
        tick();
        drain();
        chk("t5_post_count", 32'(bus.word_count), 32'd1);

        // 4) Counter wrap: one word already counted, stream up to 0xFFFF then one more
        for (int i = 0; i < 65534; i++) send(16'(i), 4'd0, 16'(i));
        drain();
        chk("t4_count_max", 32'(bus.word_count), 32'hFFFF);
        send(16'hBEEF, 4'd0, 16'hBEEF);
        drain();
        chk("t4_count_wrap", 32'(bus.word_count), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish by t=%0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
